// File: rtl/fpu_op_ctrl.sv
// Sequences one single-precision operation at a time onto the add/mul/div units
// and returns the result (or a divide-by-zero / timeout code) on a valid/ready port.
module fpu_op_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        add_start,
  output logic        mul_start,
  output logic        div_start,
  input  logic        add_done,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] add_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] div_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_err
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      unit_a_reg, unit_b_reg, rsp_result_reg;
  logic [1:0]       rsp_err_reg;
  logic             add_start_reg, mul_start_reg, div_start_reg;

  logic        sel_done;
  logic [31:0] sel_result;
  logic        div_by_zero;

  // Only the unit that was launched is listened to; other dones are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = 32'd0;
    case (op_reg)
      2'b00, 2'b01: begin sel_done = add_done; sel_result = add_result; end
      2'b10:        begin sel_done = mul_done; sel_result = mul_result; end
      default:      begin sel_done = div_done; sel_result = div_result; end
    endcase
  end

  assign div_by_zero = (op_reg == 2'b11) && (unit_b_reg[30:0] == 31'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= 2'b00;
      cnt_reg        <= '0;
      unit_a_reg     <= 32'd0;
      unit_b_reg     <= 32'd0;
      rsp_result_reg <= 32'd0;
      rsp_err_reg    <= 2'b00;
      add_start_reg  <= 1'b0;
      mul_start_reg  <= 1'b0;
      div_start_reg  <= 1'b0;
    end else begin
      add_start_reg <= 1'b0;
      mul_start_reg <= 1'b0;
      div_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg     <= req_op;
            unit_a_reg <= req_a;
            // Subtraction is an add with the sign of b flipped.
            unit_b_reg <= (req_op == 2'b01) ? {~req_b[31], req_b[30:0]} : req_b;
            // Starts are decided here so they are registered and land in ISSUE.
            add_start_reg <= (req_op[1] == 1'b0);
            mul_start_reg <= (req_op == 2'b10);
            div_start_reg <= (req_op == 2'b11) && (req_b[30:0] != 31'd0);
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (div_by_zero) begin
            rsp_result_reg <= {unit_a_reg[31] ^ unit_b_reg[31], 8'hFF, 23'd0};
            rsp_err_reg    <= 2'b01;
            state_reg      <= RESP;
          end else begin
            cnt_reg   <= '0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (sel_done) begin
            rsp_result_reg <= sel_result;
            rsp_err_reg    <= 2'b00;
            state_reg      <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            rsp_result_reg <= 32'd0;
            rsp_err_reg    <= 2'b10;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign rsp_valid  = (state_reg == RESP);
  assign unit_a     = unit_a_reg;
  assign unit_b     = unit_b_reg;
  assign add_start  = add_start_reg;
  assign mul_start  = mul_start_reg;
  assign div_start  = div_start_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_err    = rsp_err_reg;

endmodule
